// File: rtl/ws2812_pixel_source.sv
// Frame RAM plus streaming FSM that feeds brightness-scaled GRB words to the WS2812 serializer,
// with host/auto-refresh frame starts and an enforced inter-frame latch gap.
module ws2812_pixel_source #(
  parameter int NUM_LEDS       = 54,
  parameter int ADDR_W         = 6,
  parameter int GAP_CYCLES     = 6000,
  parameter int REFRESH_CYCLES = 2000000
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              wr_err,
  input  logic [7:0]        brightness,
  input  logic              frame_req,
  input  logic              auto_en,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [23:0]       px_data,
  output logic              px_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SCALE, PRESENT, GAP} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_bright;
  logic              r_pending;
  logic [RW-1:0]     r_ref;
  logic [GW-1:0]     r_gap;
  logic [23:0]       r_mem [NUM_LEDS];
  logic [2:0][7:0]   r_rd;
  logic [2:0][7:0]   w_scaled;
  logic [23:0]       r_px_data;
  logic              r_px_valid, r_px_last, r_wr_err, r_frame_done;

  logic w_wr_oob, w_ref_to, w_start, w_launch, w_accept, w_gap_end;
  logic [8:0] w_k;

  assign w_wr_oob  = {1'b0, wr_addr} >= LIM;
  assign w_ref_to  = auto_en && (r_ref == RW'(REFRESH_CYCLES - 1));
  assign w_start   = frame_req || r_pending || w_ref_to;
  assign w_launch  = (r_state == IDLE) && w_start;
  assign w_accept  = (r_state == PRESENT) && r_px_valid && px_ready;
  assign w_gap_end = (r_state == GAP) && (r_gap == GW'(GAP_CYCLES - 1));

  // RAM has no reset; reads register on the FETCH cycle so data lands in SCALE
  always_ff @(posedge sysclk) begin
    if (wr_en && !w_wr_oob) r_mem[wr_addr] <= wr_data;
    if (r_state == FETCH) r_rd <= r_mem[r_ptr];
  end

  // bright+1 makes 255 a passthrough and 0 a full blank
  assign w_k = {1'b0, r_bright} + 9'd1;
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [15:0] w_prod;
    assign w_prod      = {8'b0, r_rd[c]} * {7'b0, w_k};
    assign w_scaled[c] = w_prod[15:8];
  end

  always_ff @(posedge sysclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = FETCH;
      FETCH:   w_next = SCALE;
      SCALE:   w_next = PRESENT;
      PRESENT: if (w_accept) w_next = r_px_last ? GAP : FETCH;
      GAP:     if (w_gap_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_bright     <= '0;
      r_pending    <= 1'b0;
      r_ref        <= '0;
      r_gap        <= '0;
      r_px_data    <= '0;
      r_px_valid   <= 1'b0;
      r_px_last    <= 1'b0;
      r_wr_err     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_err     <= wr_en && w_wr_oob;
      r_frame_done <= w_gap_end;

      if (!auto_en || w_launch || w_ref_to) r_ref <= '0;
      else                                  r_ref <= r_ref + 1'b1;

      // requests arriving while busy collapse into a single pending start
      if (w_launch)                                          r_pending <= 1'b0;
      else if (r_state != IDLE && (frame_req || w_ref_to))   r_pending <= 1'b1;

      case (r_state)
        IDLE: if (w_start) begin
          r_ptr    <= '0;
          r_bright <= brightness;
        end
        SCALE: begin
          r_px_data  <= w_scaled;
          r_px_valid <= 1'b1;
          r_px_last  <= (r_ptr == LAST);
        end
        PRESENT: if (w_accept) begin
          r_px_valid <= 1'b0;
          r_px_last  <= 1'b0;
          if (r_px_last) r_gap <= '0;
          else           r_ptr <= r_ptr + 1'b1;
        end
        GAP: r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  assign px_valid   = r_px_valid;
  assign px_data    = r_px_data;
  assign px_last    = r_px_last;
  assign wr_err     = r_wr_err;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ws2812_pixel_source.sv
// Scoreboard bench for ws2812_pixel_source: expected words are queued per requested frame
// and matched against every accepted pixel.
module tb_ws2812_pixel_source;
  localparam int N  = 54;
  localparam int AW = 6;
  localparam int G  = 50;
  localparam int R  = 1000;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic [7:0]    brightness = 8'd255;
  logic          frame_req = 1'b0;
  logic          auto_en = 1'b0;
  logic          px_ready = 1'b1;
  logic          wr_err, px_valid, px_last, busy, frame_done;
  logic [23:0]   px_data;

  ws2812_pixel_source #(.NUM_LEDS(N), .ADDR_W(AW), .GAP_CYCLES(G), .REFRESH_CYCLES(R)) dut (
    .sysclk(sysclk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .brightness(brightness), .frame_req(frame_req), .auto_en(auto_en),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_last(px_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [23:0] mdl [N];
  logic [24:0] sb [$];
  int cyc = 0;
  always @(posedge sysclk) cyc++;

  // monitor: sampled on the falling edge, between driver updates
  int          beats = 0, n_done = 0, last_acc = 0;
  int          starts [$];
  int          dones [$];
  logic [23:0] first_px = '0;
  logic [23:0] p_data = '0;
  logic        p_busy = 1'b0, p_stall = 1'b0;
  logic [24:0] e;
  always @(negedge sysclk) begin
    if (rst) begin
      beats = 0; p_stall = 1'b0; p_busy = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_valid", px_valid, 1);
        chk("hold_data", px_data, p_data);
      end
      if (busy && !p_busy) starts.push_back(cyc);
      if (px_valid && px_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("px_data", px_data, e[23:0]);
          chk("px_last", px_last, e[24]);
        end
        if (beats == 0) first_px = px_data;
        beats++;
        last_acc = cyc;
      end
      if (frame_done) begin
        chk("done_gap", cyc - last_acc, G + 1);
        chk("beats", beats, N);
        beats = 0;
        n_done++;
        dones.push_back(cyc);
      end
      p_stall = px_valid && !px_ready;
      p_data  = px_data;
      p_busy  = busy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < N) mdl[a] = d;
  endtask

  function automatic logic [23:0] scl(input logic [23:0] w, input int b);
    int g, r, bl;
    g  = int'(w[23:16]) * (b + 1) / 256;
    r  = int'(w[15:8])  * (b + 1) / 256;
    bl = int'(w[7:0])   * (b + 1) / 256;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  task automatic push_frame(input int b);
    for (int i = 0; i < N; i++) sb.push_back({(i == N - 1), scl(mdl[i], b)});
  endtask

  task automatic req();
    frame_req = 1'b1; tick(); frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    chk("done_timeout", n_done, target);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beats < target && k < budget) begin tick(); k++; end
    chk("beat_timeout", beats >= target, 1);
  endtask

  initial begin
    int a, n0, nd;
    tick(3);
    chk("rst_valid", px_valid, 0);
    chk("rst_data", px_data, 0);
    chk("rst_last", px_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) wr(i, 24'($urandom()));
    wr(0, 24'h112233);
    wr(53, 24'hA0B0C0);
    chk("wr_err_53", wr_err, 0);

    // full-brightness passthrough frame
    brightness = 8'd255;
    push_frame(255); req();
    wait_done(1, 1000);

    // half brightness, latched at start despite a later change
    wr(0, 24'hFF8001);
    brightness = 8'd128;
    push_frame(128); req();
    tick(2); brightness = 8'd7;
    wait_done(2, 1000);
    chk("b128_px0", first_px, 24'h804000);

    brightness = 8'd0;
    push_frame(0); req();
    wait_done(3, 1000);
    chk("b0_px0", first_px, 24'h000000);

    // backpressure on beat 5
    brightness = 8'd255;
    push_frame(255); req();
    wait_beats(5, 200);
    px_ready = 1'b0; tick(10); px_ready = 1'b1;
    wait_done(4, 1000);

    // three requests during a frame merge into one follow-on frame
    push_frame(255); req();
    wait_beats(10, 200); push_frame(255); req();
    wait_beats(20, 200); req();
    wait_beats(30, 200); req();
    wait_done(6, 2000);
    chk("restart_lat", starts[starts.size()-1] - dones[dones.size()-2], 1);
    tick(300);
    chk("no_extra_frame", starts.size(), 6);

    wr(60, 24'hDEAD00);
    chk("wr_err_60", wr_err, 1);
    tick();
    chk("wr_err_pulse", wr_err, 0);

    // auto-refresh
    a = cyc; n0 = starts.size();
    push_frame(255); push_frame(255); push_frame(255);
    auto_en = 1'b1;
    tick(3500);
    auto_en = 1'b0;
    tick(2000);
    chk("auto_count", starts.size() - n0, 3);
    chk("auto_first", starts[n0] - a, R);
    chk("auto_period1", starts[n0+1] - starts[n0], R);
    chk("auto_period2", starts[n0+2] - starts[n0+1], R);
    chk("auto_done", n_done, 9);

    // reset mid-frame
    push_frame(255); req();
    wait_beats(20, 200);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_valid", px_valid, 0);
    chk("rst_mid_busy", busy, 0);
    sb.delete();
    nd = n_done;
    tick(200);
    chk("rst_no_done", n_done, nd);
    push_frame(255); req();
    wait_done(nd + 1, 1000);
    chk("rst_px0", first_px, mdl[0]);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
